cpu_interlock: RTL and testbench

Pipeline interlock controller for the moxie core. It scoreboards register writes that have been issued past decode but not yet written back, and tracks the busy window of the long-latency multiply/divide unit. From these it generates the stall that holds fetch and the decode stage, which turns stalled slots into `OP_NOP`. It sits beside cpu_decode and takes operand indices from the fetch/decode boundary and write-back retirements from the write stage.

---
 rtl/cpu_interlock_pkg.sv | 14 +
 rtl/cpu_sb_counter.sv | 50 +++++
 rtl/cpu_interlock.sv | 133 +++++++++++++
 tb/tb_cpu_interlock.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_interlock_pkg.sv
// ----------------------------------------------------------------------------
// cpu_interlock_pkg
// Shared constants for the moxie pipeline interlock: the architectural
// register count, index constants for the frame and stack pointers, and the
// default busy window of the multiply/divide unit.
// ----------------------------------------------------------------------------
package cpu_interlock_pkg;

    localparam int NUM_REGS         = 16;
    localparam int REG_FP           = 0;
    localparam int REG_SP           = 1;
    localparam int LONG_LAT_DEFAULT = 34;

endpackage : cpu_interlock_pkg

// File: rtl/cpu_sb_counter.sv
// ----------------------------------------------------------------------------
// cpu_sb_counter
// Pending-write counter for one architectural register.
// Ports:
//   clk_i        core clock
//   rst_i        asynchronous, active-high reset (clears the count)
//   inc_i        a write to this register issued this cycle
//   dec_i        a write to this register retired this cycle
//   value_o      current count of in-flight writes
//   nonzero_o    value_o != 0
//   full_o       value_o is all-ones (no room for another write)
//   underflow_o  retire seen with nothing in flight (combinational)
// ----------------------------------------------------------------------------
module cpu_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             nonzero_o,
    output logic             full_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] r_value;

    assign value_o     = r_value;
    assign nonzero_o   = (r_value != '0);
    assign full_o      = (r_value == '1);
    // An issue and a retire in the same cycle cancel, even at zero.
    assign underflow_o = dec_i & ~inc_i & ~nonzero_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_value <= '0;
        end else if (inc_i & ~dec_i) begin
            // Saturate rather than wrap; the top flags this as an error.
            if (!full_o) begin
                r_value <= r_value + 1'b1;
            end
        end else if (dec_i & ~inc_i) begin
            if (nonzero_o) begin
                r_value <= r_value - 1'b1;
            end
        end
    end

endmodule : cpu_sb_counter

// File: rtl/cpu_interlock.sv
// ----------------------------------------------------------------------------
// cpu_interlock
// Issue interlock for the moxie core. Tracks in-flight register writes with a
// per-register counter and the busy window of the long-latency mul/div unit,
// and stalls fetch/decode while the presented instruction has a RAW hazard,
// would overflow its destination counter, or the long unit is busy.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i             instruction presented this cycle
//   riA_i/riB_i         operand register indices; rdA_i/rdB_i qualify them
//   wr_i/wr_index_i     instruction writes wr_index_i
//   long_i              instruction uses the long-latency unit
//   flush_i             presented instruction is discarded
//   wb_en_i/wb_index_i  register write retiring from write-back
//   stall_o, issue_o    combinational stall / issue for the presented slot
//   pending_o           per-register "write in flight" (registered)
//   long_busy_o         long unit busy (registered)
//   err_o               sticky scoreboard underflow/overflow
// ----------------------------------------------------------------------------
module cpu_interlock
    import cpu_interlock_pkg::*;
#(
    parameter int NREGS    = NUM_REGS,
    parameter int CNT_W    = 2,
    parameter int LONG_LAT = LONG_LAT_DEFAULT,
    parameter int LONG_W   = 6,
    localparam int IDX_W   = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] riA_i,
    input  logic [IDX_W-1:0] riB_i,
    input  logic             rdA_i,
    input  logic             rdB_i,
    input  logic             wr_i,
    input  logic [IDX_W-1:0] wr_index_i,
    input  logic             long_i,
    input  logic             flush_i,
    input  logic             wb_en_i,
    input  logic [IDX_W-1:0] wb_index_i,
    output logic             stall_o,
    output logic             issue_o,
    output logic [NREGS-1:0] pending_o,
    output logic             long_busy_o,
    output logic             err_o
);

    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_dec;
    logic [NREGS-1:0]  w_nonzero;
    logic [NREGS-1:0]  w_full;
    logic [NREGS-1:0]  w_underflow;
    logic [CNT_W-1:0]  w_value [NREGS];

    logic              w_raw_a;
    logic              w_raw_b;
    logic              w_sat;
    logic              w_lng;
    logic              w_present;
    logic              w_overflow;

    logic [LONG_W-1:0] r_long_cnt;
    logic              r_err;

    // ------------------------------------------------------------------
    // Per-register pending-write counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_sb
            assign w_inc[gi] = issue_o & wr_i & (wr_index_i == IDX_W'(gi));
            assign w_dec[gi] = wb_en_i & (wb_index_i == IDX_W'(gi));

            cpu_sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .inc_i       (w_inc[gi]),
                .dec_i       (w_dec[gi]),
                .value_o     (w_value[gi]),
                .nonzero_o   (w_nonzero[gi]),
                .full_o      (w_full[gi]),
                .underflow_o (w_underflow[gi])
            );
        end
    endgenerate

    assign pending_o = w_nonzero;

    // ------------------------------------------------------------------
    // Hazard detection and issue. No write-back forwarding: a register
    // retiring this cycle still reads as pending until the next edge.
    // ------------------------------------------------------------------
    assign w_raw_a   = rdA_i & (w_value[riA_i] != '0);
    assign w_raw_b   = rdB_i & (w_value[riB_i] != '0);
    assign w_sat     = wr_i & w_full[wr_index_i];
    assign w_lng     = (r_long_cnt != '0);
    assign w_present = valid_i & ~flush_i;

    assign stall_o     = w_present & (w_raw_a | w_raw_b | w_sat | w_lng);
    assign issue_o     = w_present & ~stall_o;
    assign long_busy_o = w_lng;

    // An increment into a full counter is blocked by w_sat, so this only
    // fires if the scoreboard has been corrupted some other way.
    assign w_overflow = |(w_inc & ~w_dec & w_full);

    // ------------------------------------------------------------------
    // Long-unit busy window: loaded on issue, counts down to zero.
    // A long op held off by a busy unit does not reload the counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_long_cnt <= '0;
        end else if (issue_o & long_i) begin
            r_long_cnt <= LONG_W'(LONG_LAT - 1);
        end else if (w_lng) begin
            r_long_cnt <= r_long_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if ((|w_underflow) | w_overflow) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule : cpu_interlock

// File: tb/tb_cpu_interlock.sv
// ----------------------------------------------------------------------------
// tb_cpu_interlock
// Directed stimulus for cpu_interlock. Each cycle the stimulus process drives
// the inputs just after the rising edge and queues the outputs it expects for
// that cycle; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_cpu_interlock;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  riA_i;
    logic [3:0]  riB_i;
    logic        rdA_i;
    logic        rdB_i;
    logic        wr_i;
    logic [3:0]  wr_index_i;
    logic        long_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [3:0]  wb_index_i;
    logic        stall_o;
    logic        issue_o;
    logic [15:0] pending_o;
    logic        long_busy_o;
    logic        err_o;

    always #5 clk = ~clk;

    cpu_interlock dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .riA_i       (riA_i),
        .riB_i       (riB_i),
        .rdA_i       (rdA_i),
        .rdB_i       (rdB_i),
        .wr_i        (wr_i),
        .wr_index_i  (wr_index_i),
        .long_i      (long_i),
        .flush_i     (flush_i),
        .wb_en_i     (wb_en_i),
        .wb_index_i  (wb_index_i),
        .stall_o     (stall_o),
        .issue_o     (issue_o),
        .pending_o   (pending_o),
        .long_busy_o (long_busy_o),
        .err_o       (err_o)
    );

    typedef struct {
        string       name;
        logic        stall;
        logic        issue;
        logic [15:0] pend;
        logic        lb;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if ({stall_o, issue_o, pending_o, long_busy_o, err_o} !==
                {e.stall, e.issue, e.pend, e.lb, e.err}) begin
                n_miss++;
                $display("FAIL %s: got stall=%b issue=%b pend=%h lbusy=%b err=%b, want stall=%b issue=%b pend=%h lbusy=%b err=%b",
                         e.name, stall_o, issue_o, pending_o, long_busy_o, err_o,
                         e.stall, e.issue, e.pend, e.lb, e.err);
            end else begin
                $display("ok   %s: stall=%b issue=%b pend=%h lbusy=%b err=%b",
                         e.name, stall_o, issue_o, pending_o, long_busy_o, err_o);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        riA_i      = '0;
        riB_i      = '0;
        rdA_i      = 1'b0;
        rdB_i      = 1'b0;
        wr_i       = 1'b0;
        wr_index_i = '0;
        long_i     = 1'b0;
        flush_i    = 1'b0;
        wb_en_i    = 1'b0;
        wb_index_i = '0;
    endtask

    task automatic chk(input string nm, input logic s, input logic i,
                       input logic [15:0] p, input logic lb, input logic e);
        exp_t x;
        x.name  = nm;
        x.stall = s;
        x.issue = i;
        x.pend  = p;
        x.lb    = lb;
        x.err   = e;
        q.push_back(x);
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        riA_i      = '0;
        riB_i      = '0;
        rdA_i      = 1'b0;
        rdB_i      = 1'b0;
        wr_i       = 1'b0;
        wr_index_i = '0;
        long_i     = 1'b0;
        flush_i    = 1'b0;
        wb_en_i    = 1'b0;
        wb_index_i = '0;

        // 1. reset, then an idle issue
        tick(); chk("rst_c0", 0, 0, 16'h0000, 0, 0);
        tick(); chk("rst_c1", 0, 0, 16'h0000, 0, 0);
        tick(); rst_i = 1'b0; valid_i = 1'b1;
        chk("idle_issue", 0, 1, 16'h0000, 0, 0);

        // 2. RAW hazard on idx 7, retired during the third stall cycle
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd7;
        chk("raw_wr7", 0, 1, 16'h0000, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); valid_i = 1'b1; rdA_i = 1'b1; riA_i = 4'd7;
            if (k == 2) begin
                wb_en_i = 1'b1; wb_index_i = 4'd7;
            end
            chk("raw_stall", 1, 0, 16'h0080, 0, 0);
        end
        tick(); valid_i = 1'b1; rdA_i = 1'b1; riA_i = 4'd7;
        chk("raw_issue", 0, 1, 16'h0000, 0, 0);

        // 3. same-cycle inc/dec on idx 3
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd3;
        chk("sd_wr3", 0, 1, 16'h0000, 0, 0);
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd3;
        wb_en_i = 1'b1; wb_index_i = 4'd3;
        chk("sd_incdec", 0, 1, 16'h0008, 0, 0);
        tick(); wb_en_i = 1'b1; wb_index_i = 4'd3;
        chk("sd_hold", 0, 0, 16'h0008, 0, 0);
        tick(); chk("sd_clear", 0, 0, 16'h0000, 0, 0);

        // 4. saturation of idx 4
        for (int k = 0; k < 3; k++) begin
            tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd4;
            chk("sat_wr", 0, 1, (k == 0) ? 16'h0000 : 16'h0010, 0, 0);
        end
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd4;
        wb_en_i = 1'b1; wb_index_i = 4'd4;
        chk("sat_stall", 1, 0, 16'h0010, 0, 0);
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd4;
        chk("sat_issue", 0, 1, 16'h0010, 0, 0);
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd4;
        chk("sat_full_again", 1, 0, 16'h0010, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); wb_en_i = 1'b1; wb_index_i = 4'd4;
            chk("sat_drain", 0, 0, 16'h0010, 0, 0);
        end
        tick(); chk("sat_empty", 0, 0, 16'h0000, 0, 0);

        // 5. long op: 33 blocked cycles; a blocked long op must not reload
        tick(); valid_i = 1'b1; long_i = 1'b1;
        chk("long_issue", 0, 1, 16'h0000, 0, 0);
        for (int k = 1; k <= 33; k++) begin
            tick(); valid_i = 1'b1;
            if (k == 33) long_i = 1'b1;
            chk("long_stall", 1, 0, 16'h0000, 1, 0);
        end
        tick(); valid_i = 1'b1;
        chk("long_release", 0, 1, 16'h0000, 0, 0);

        // 6. operand B hazard, flush priority, underflow
        tick(); valid_i = 1'b1; wr_i = 1'b1; wr_index_i = 4'd2;
        chk("fl_wr2", 0, 1, 16'h0000, 0, 0);
        tick(); valid_i = 1'b1; rdB_i = 1'b1; riB_i = 4'd2;
        chk("rawB_stall", 1, 0, 16'h0004, 0, 0);
        tick(); valid_i = 1'b1; rdA_i = 1'b1; riA_i = 4'd2;
        wr_i = 1'b1; wr_index_i = 4'd5; flush_i = 1'b1;
        chk("flush", 0, 0, 16'h0004, 0, 0);
        tick(); wb_en_i = 1'b1; wb_index_i = 4'd2;
        chk("fl_nochange", 0, 0, 16'h0004, 0, 0);
        tick(); wb_en_i = 1'b1; wb_index_i = 4'd9;
        chk("uf_wb9", 0, 0, 16'h0000, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); chk("err_sticky", 0, 0, 16'h0000, 0, 1);
        end
        tick(); rst_i = 1'b1;
        chk("err_rst", 0, 0, 16'h0000, 0, 0);
        tick(); rst_i = 1'b0; valid_i = 1'b1;
        chk("post_rst", 0, 1, 16'h0000, 0, 0);

        // let the monitor drain the last expectation
        tick();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_cpu_interlock
